debounced_input_port: RTL and testbench

Avalon-MM slave input peripheral: the read-side counterpart of the seven-segment output peripheral. Samples N asynchronous pushbutton/switch lines and synchronizes and debounces them. Exposes the debounced level, latched press edges and an interrupt mask to the Nios II CPU through a 4-word register map. Sits on the same system interconnect as the display peripheral and drives one IRQ line.

---
 rtl/input_port_pkg.sv | 21 ++
 rtl/debounce_cell.sv | 59 +++++
 rtl/debounced_input_port.sv | 127 ++++++++++++
 tb/tb_debounced_input_port.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_port_pkg.sv
// Shared definitions for the debounced pushbutton/switch input peripheral:
// register offsets, default debounce length and small helpers.
package input_port_pkg;

  // Word offsets of the Avalon-MM register map.
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_EDGE    = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_RAW     = 2'd3
  } reg_addr_e;

  // 1 ms at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Width of the debounce counter; never narrower than one bit.
  function automatic int debounce_cnt_width(input int cycles);
    debounce_cnt_width = (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input bit: 2-FF synchronizer (holding the already inverted level so
// that reset means "released"), debounce counter and accepted-level register.
module debounce_cell
  import input_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_stable
);

  localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          w_pin_pressed;
  logic          r_sync_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Inversion ahead of the synchronizer keeps the reset value 0 = released.
  assign w_pin_pressed = i_pin ^ ACTIVE_LOW;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_sync_meta <= w_pin_pressed;
      r_sync      <= r_sync_meta;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync == r_stable) begin
      r_cnt    <= '0;
      r_stable <= r_stable;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= r_sync;
    end else begin
      r_cnt    <= r_cnt + CW'(1);
      r_stable <= r_stable;
    end
  end

  assign o_sync   = r_sync;
  assign o_stable = r_stable;

endmodule

// File: rtl/debounced_input_port.sv
// Avalon-MM input peripheral: N debounced inputs, press-edge capture with
// write-1-to-clear, interrupt mask and a level IRQ to the CPU.
module debounced_input_port
  import input_port_pkg::*;
#(
  parameter int N_INPUTS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [N_INPUTS-1:0] buttons_in,
  output logic                irq
);

  logic [N_INPUTS-1:0] w_sync;
  logic [N_INPUTS-1:0] w_stable;
  logic [N_INPUTS-1:0] w_rise;
  logic [N_INPUTS-1:0] w_edge_clr;
  logic [N_INPUTS-1:0] w_wdata;
  logic                w_rd_en;
  logic                w_wr_en;
  logic [31:0]         w_rd_mux;
  logic                w_unused_wdata;

  logic [N_INPUTS-1:0] r_stable_d;
  logic [N_INPUTS-1:0] r_edge;
  logic [N_INPUTS-1:0] r_irqmask;
  logic [31:0]         r_readdata;

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi = gi + 1) begin : g_cell
      debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_cell (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_pin    (buttons_in[gi]),
        .o_sync   (w_sync[gi]),
        .o_stable (w_stable[gi])
      );
    end
  endgenerate

  assign w_rd_en        = chipselect & read;
  assign w_wr_en        = chipselect & write;
  assign w_wdata        = writedata[N_INPUTS-1:0];
  // Upper write-data bits are intentionally ignored by every register.
  assign w_unused_wdata = ^writedata;

  // Press edges only; releases are not captured.
  assign w_rise = w_stable & ~r_stable_d;

  // Bits software asks to clear in EDGE this cycle.
  always_comb begin
    w_edge_clr = '0;
    if (w_wr_en && (address == REG_EDGE)) begin
      w_edge_clr = w_wdata;
    end else begin
      w_edge_clr = '0;
    end
  end

  // Delayed copy of the accepted levels for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_d <= '0;
    end else begin
      r_stable_d <= w_stable;
    end
  end

  // Edge capture: a new press wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
    end
  end

  // Interrupt mask register; only the implemented bits are stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqmask <= '0;
    end else if (w_wr_en && (address == REG_IRQMASK)) begin
      r_irqmask <= w_wdata;
    end else begin
      r_irqmask <= r_irqmask;
    end
  end

  // Read mux, unimplemented upper bits read as zero.
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      REG_DATA:    w_rd_mux = 32'(w_stable);
      REG_EDGE:    w_rd_mux = 32'(r_edge);
      REG_IRQMASK: w_rd_mux = 32'(r_irqmask);
      REG_RAW:     w_rd_mux = 32'(w_sync);
      default:     w_rd_mux = 32'd0;
    endcase
  end

  // Registered read data; holds its value until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= 32'd0;
    end else if (w_rd_en) begin
      r_readdata <= w_rd_mux;
    end else begin
      r_readdata <= r_readdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_irqmask);

endmodule

// File: tb/tb_debounced_input_port.sv
// Directed scoreboard bench for debounced_input_port (N=4, 4-cycle debounce).
module tb_debounced_input_port;
  import input_port_pkg::*;

  localparam int N  = 4;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [N-1:0] buttons_in;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  debounced_input_port #(
    .N_INPUTS        (N),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .buttons_in (buttons_in),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one read at a negedge; result is compared at the following negedge.
  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    string       t;
    logic [31:0] e;
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    address    = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check(t, readdata, e);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    read       = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
    buttons_in = 4'b0000;   // all pressed through reset

    // Reset state
    tick(3);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // Held press accepted 2+DC cycles after release, then an edge.
    for (int i = 0; i < 7; i++) begin
      bus_read(REG_DATA, (i < 6) ? 32'h0 : 32'hF, "rst_data");
    end
    bus_read(REG_EDGE, 32'hF, "rst_edge");
    check("rst_irq_masked", 32'(irq), 32'd0);

    // Release everything: no edges on release.
    bus_write(REG_EDGE, 32'hF);
    buttons_in = 4'b1111;
    tick(10);
    bus_read(REG_DATA, 32'h0, "released_data");
    bus_read(REG_EDGE, 32'h0, "released_edge");

    // 3-cycle glitch rejected.
    buttons_in[0] = 1'b0;
    tick(3);
    buttons_in[0] = 1'b1;
    tick(10);
    bus_read(REG_DATA, 32'h0, "glitch_data");
    bus_read(REG_EDGE, 32'h0, "glitch_edge");

    // Real press: DATA exactly 6 cycles after pin change, EDGE one later.
    buttons_in[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus_read(REG_DATA, (i < 6) ? 32'h0 : 32'h1, "press_data");
    end
    bus_read(REG_EDGE, 32'h1, "press_edge");

    // Interrupt on masked bit 1, rises with the edge bit.
    bus_write(REG_EDGE, 32'h1);
    bus_write(REG_IRQMASK, 32'h2);
    buttons_in[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("irq_rise", 32'(irq), (i == 7) ? 32'd1 : 32'd0);
    end
    bus_read(REG_EDGE, 32'h2, "irq_edge");
    bus_write(REG_EDGE, 32'h2);
    check("irq_fall", 32'(irq), 32'd0);

    // Unmasked bit 0 press: edge captured, no irq.
    buttons_in[0] = 1'b1;
    tick(10);
    buttons_in[0] = 1'b0;
    tick(10);
    check("irq_unmasked", 32'(irq), 32'd0);
    bus_read(REG_EDGE, 32'h1, "unmasked_edge");

    // Set wins over simultaneous write-1-to-clear.
    bus_write(REG_EDGE, 32'hF);
    buttons_in[2] = 1'b0;
    tick(6);
    bus_write(REG_EDGE, 32'h4);
    bus_read(REG_EDGE, 32'h4, "set_wins");

    // Release of bit 3 not captured.
    buttons_in[3] = 1'b0;
    tick(10);
    bus_write(REG_EDGE, 32'hF);
    buttons_in[3] = 1'b1;
    tick(10);
    bus_read(REG_DATA, 32'h7, "release_data");
    bus_read(REG_EDGE, 32'h0, "release_edge");

    // Register access.
    bus_write(REG_IRQMASK, 32'hFFFF_FFFF);
    bus_read(REG_IRQMASK, 32'h0000_000F, "mask_width");
    bus_write(REG_DATA, 32'hA);
    bus_read(REG_DATA, 32'h7, "data_ro");
    buttons_in[0] = 1'b1;
    tick(2);
    bus_read(REG_RAW, 32'h6, "raw_read");
    bus_read(REG_DATA, 32'h7, "data_lags_raw");

    // Read and write together: write lands, read returns the old value.
    chipselect = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    address    = REG_IRQMASK;
    writedata  = 32'h3;
    exp_q.push_back(32'hF);
    tag_q.push_back("rw_collide_old");
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    begin
      string       t;
      logic [31:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, readdata, e);
    end
    bus_read(REG_IRQMASK, 32'h3, "rw_collide_new");
    tick(10);
    bus_read(REG_DATA, 32'h6, "data_settled");

    // Reset mid-debounce discards everything.
    buttons_in[3] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("midrst_readdata", readdata, 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    bus_read(REG_DATA, 32'h0, "midrst_data");
    bus_read(REG_IRQMASK, 32'h0, "midrst_mask");
    tick(10);
    bus_read(REG_DATA, 32'hE, "midrst_data_after");
    bus_read(REG_EDGE, 32'hE, "midrst_edge_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
